// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read ports, two write ports, scoreboard set and clear control.
// Signal names match the register file's port list; widths follow the parameters.
interface register_file_mp_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 3
);
  logic [1:0]                     i_we;
  logic [2*ADDR_WIDTH-1:0]        i_wr_addr;
  logic [2*DATA_WIDTH-1:0]        i_wr_data;
  logic [NUM_RD*ADDR_WIDTH-1:0]   i_rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]   o_rd_data;
  logic [NUM_RD-1:0]              o_rd_pending;
  logic                           i_sb_set;
  logic [ADDR_WIDTH-1:0]          i_sb_addr;
  logic                           i_clr_req;
  logic                           o_busy;
  logic                           o_clr_done;

  modport master (
    output i_we, i_wr_addr, i_wr_data, i_rd_addr, i_sb_set, i_sb_addr, i_clr_req,
    input  o_rd_data, o_rd_pending, o_busy, o_clr_done
  );

  modport slave (
    input  i_we, i_wr_addr, i_wr_data, i_rd_addr, i_sb_set, i_sb_addr, i_clr_req,
    output o_rd_data, o_rd_pending, o_busy, o_clr_done
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port RV32I register file with pending scoreboard and sequential clear engine.
// Optional write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module register_file_mp #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 3
) (
  input  logic                clk,
  input  logic                rst,
  register_file_mp_if.slave   bus
);
  localparam int unsigned NREG = 2 ** ADDR_WIDTH;
  localparam int unsigned NWR  = 2;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   regs_q [NREG];
  logic [DATA_WIDTH-1:0]   regs_d [NREG];
  logic [NREG-1:0]         pend_q, pend_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      regs_q  <= '{default: '0};
      pend_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept writes/scoreboard only in IDLE; CLEAR zeroes one entry per cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    regs_d    = regs_q;
    pend_d    = pend_q;
    wr_addr_c = '0;
    unique case (state_q)
      IDLE: begin
        // Port 1 is applied last so it wins on an address collision.
        for (int unsigned p = 0; p < NWR; p++) begin
          wr_addr_c = bus.i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
          if (bus.i_we[p] && (wr_addr_c != '0)) begin
            regs_d[wr_addr_c] = bus.i_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
            pend_d[wr_addr_c] = 1'b0;
          end
        end
        if (bus.i_sb_set && (bus.i_sb_addr != '0)) begin
          pend_d[bus.i_sb_addr] = 1'b1;
        end
        if (bus.i_clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[idx_q] = '0;
        pend_d[idx_q] = 1'b0;
        idx_d         = idx_q + ADDR_WIDTH'(1);
        if (idx_q == ADDR_WIDTH'(NREG - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
    done_d = (state_d == DONE);
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_clr_done = done_q;

  // Combinational read ports; x0 and reset force zero.
  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rp;
    bus.o_rd_data    = '0;
    bus.o_rd_pending = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      ra = bus.i_rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
      rd = regs_q[ra];
      rp = pend_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (state_q == IDLE) begin
        for (int unsigned p = 0; p < NWR; p++) begin
          if (bus.i_we[p] && (bus.i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
            rd = bus.i_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
            rp = bus.i_sb_set && (bus.i_sb_addr == ra);
          end
        end
      end
`endif
      if (rst || (ra == '0)) begin
        rd = '0;
        rp = 1'b0;
      end
      bus.o_rd_data[r*DATA_WIDTH +: DATA_WIDTH] = rd;
      bus.o_rd_pending[r]                       = rp;
    end
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_register_file_mp;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NR   = 3;
  localparam int unsigned NREG = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) bus();
  register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents, pending bits, and cycles into an active clear
  // (0 = idle, 1..NREG = clearing entry n-1, NREG+1 = done cycle).
  logic [DW-1:0]   mdl_regs [NREG];
  logic [NREG-1:0] mdl_pend;
  int              mdl_clr;

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) mdl_regs[i] = '0;
    mdl_pend = '0;
    mdl_clr  = 0;
  endtask

  function automatic logic [AW-1:0] waddr(input int p);
    return bus.i_wr_addr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdata(input int p);
    return bus.i_wr_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    if (rst || a == '0) return '0;
    d = mdl_regs[a];
`ifdef REGFILE_MP_BYPASS_EN
    if (mdl_clr == 0)
      for (int p = 0; p < 2; p++)
        if (bus.i_we[p] && waddr(p) == a) d = wdata(p);
`endif
    return d;
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    logic v;
    if (rst || a == '0) return 1'b0;
    v = mdl_pend[a];
`ifdef REGFILE_MP_BYPASS_EN
    if (mdl_clr == 0 && ((bus.i_we[0] && waddr(0) == a) || (bus.i_we[1] && waddr(1) == a)))
      v = bus.i_sb_set && (bus.i_sb_addr == a);
`endif
    return v;
  endfunction

  task automatic idle_inputs();
    bus.i_we      = '0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
    bus.i_sb_set  = 1'b0;
    bus.i_sb_addr = '0;
    bus.i_clr_req = 1'b0;
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    bus.i_rd_addr[r*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_we[p]            = 1'b1;
    bus.i_wr_addr[p*AW +: AW] = a;
    bus.i_wr_data[p*DW +: DW] = d;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic step();
    if (rst) begin
      model_reset();
    end else if (mdl_clr == 0) begin
      for (int p = 0; p < 2; p++)
        if (bus.i_we[p] && waddr(p) != '0) begin
          mdl_regs[waddr(p)] = wdata(p);
          mdl_pend[waddr(p)] = 1'b0;
        end
      if (bus.i_sb_set && bus.i_sb_addr != '0) mdl_pend[bus.i_sb_addr] = 1'b1;
      if (bus.i_clr_req) mdl_clr = 1;
    end else if (mdl_clr <= int'(NREG)) begin
      mdl_regs[mdl_clr-1] = '0;
      mdl_pend[mdl_clr-1] = 1'b0;
      mdl_clr++;
    end else begin
      mdl_clr = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [AW-1:0] addrs [3];
    addrs = '{5'd0, 5'd5, 5'd31};
    rst = 1'b1;
    idle_inputs();
    bus.i_rd_addr = '0;
    model_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < int'(NR); r++) set_rd(r, addrs[k]);
      #1;
      for (int r = 0; r < int'(NR); r++) begin
        n_checks++;
        if (bus.o_rd_data[r*DW +: DW] !== '0 || bus.o_rd_pending[r] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_read port%0d addr%0d: got %h/%b expected 0/0", r, addrs[k],
                   bus.o_rd_data[r*DW +: DW], bus.o_rd_pending[r]);
        end
      end
    end
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b expected 0/0", bus.o_busy, bus.o_clr_done);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_write_priority();
    idle_inputs();
    set_wr(0, 5'd7, 32'hDEADBEEF);
    set_wr(1, 5'd7, 32'h12345678);
    step();
    idle_inputs();
    set_rd(0, 5'd7);
    #1;
    n_checks++;
    if (bus.o_rd_data[0 +: DW] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL port1_wins: got %h expected 12345678", bus.o_rd_data[0 +: DW]);
    end
    set_wr(0, 5'd0, 32'hFFFFFFFF);
    step();
    idle_inputs();
    for (int r = 0; r < int'(NR); r++) set_rd(r, 5'd0);
    #1;
    n_checks++;
    if (bus.o_rd_data !== '0) begin
      n_fail++;
      $display("FAIL x0_write: got %h expected 0", bus.o_rd_data);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    bus.i_sb_set  = 1'b1;
    bus.i_sb_addr = 5'd3;
    step();
    idle_inputs();
    set_rd(1, 5'd3);
    #1;
    n_checks++;
    if (bus.o_rd_pending[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set: pending got %b expected 1", bus.o_rd_pending[1]);
    end
    set_wr(0, 5'd3, 32'h00000033);
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.o_rd_pending[1] !== 1'b0 || bus.o_rd_data[DW +: DW] !== 32'h00000033) begin
      n_fail++;
      $display("FAIL sb_clear: got %h/%b expected 00000033/0", bus.o_rd_data[DW +: DW],
               bus.o_rd_pending[1]);
    end
    set_wr(1, 5'd3, 32'h00000044);
    bus.i_sb_set  = 1'b1;
    bus.i_sb_addr = 5'd3;
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.o_rd_pending[1] !== 1'b1 || bus.o_rd_data[DW +: DW] !== 32'h00000044) begin
      n_fail++;
      $display("FAIL sb_set_wins: got %h/%b expected 00000044/1", bus.o_rd_data[DW +: DW],
               bus.o_rd_pending[1]);
    end
    // Pending on x0 must stay clear.
    bus.i_sb_set  = 1'b1;
    bus.i_sb_addr = 5'd0;
    step();
    idle_inputs();
    set_rd(2, 5'd0);
    #1;
    n_checks++;
    if (bus.o_rd_pending[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_x0: pending got %b expected 0", bus.o_rd_pending[2]);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      idle_inputs();
      for (int p = 0; p < 2; p++) begin
        bus.i_we[p] = ($urandom_range(0, 3) != 0);
        bus.i_wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        bus.i_wr_data[p*DW +: DW] = $urandom;
      end
      bus.i_sb_set  = ($urandom_range(0, 2) == 0);
      bus.i_sb_addr = AW'($urandom_range(0, 7));
      for (int r = 0; r < int'(NR); r++) set_rd(r, AW'($urandom_range(0, 8)));
      #1;
      for (int r = 0; r < int'(NR); r++) begin
        n_checks++;
        if (bus.o_rd_data[r*DW +: DW] !== exp_data(bus.i_rd_addr[r*AW +: AW]) ||
            bus.o_rd_pending[r] !== exp_pend(bus.i_rd_addr[r*AW +: AW])) begin
          n_fail++;
          $display("FAIL random_read c%0d port%0d: got %h/%b expected %h/%b", c, r,
                   bus.o_rd_data[r*DW +: DW], bus.o_rd_pending[r],
                   exp_data(bus.i_rd_addr[r*AW +: AW]), exp_pend(bus.i_rd_addr[r*AW +: AW]));
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt;
    int done_cyc;
    idle_inputs();
    for (int i = 1; i < int'(NREG); i++) begin
      bus.i_sb_set  = 1'b1;
      bus.i_sb_addr = AW'(i);
      step();
      idle_inputs();
      set_wr(0, AW'(i), DW'(i));
      step();
      idle_inputs();
    end
    bus.i_clr_req = 1'b1;
    step();
    idle_inputs();
    busy_cnt = 0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      set_rd(0, AW'($urandom_range(0, 31)));
      if (cyc == 10) begin
        set_wr(0, 5'd2, 32'h0BAD0BAD);
        bus.i_sb_set  = 1'b1;
        bus.i_sb_addr = 5'd2;
        bus.i_clr_req = 1'b1;
      end
      #1;
      n_checks++;
      if (bus.o_busy !== (mdl_clr >= 1 && mdl_clr <= int'(NREG)) ||
          bus.o_clr_done !== (mdl_clr == int'(NREG) + 1) ||
          bus.o_rd_data[0 +: DW] !== exp_data(bus.i_rd_addr[0 +: AW])) begin
        n_fail++;
        $display("FAIL clear_cycle%0d: busy=%b done=%b rd=%h expected rd=%h phase=%0d", cyc,
                 bus.o_busy, bus.o_clr_done, bus.o_rd_data[0 +: DW],
                 exp_data(bus.i_rd_addr[0 +: AW]), mdl_clr);
      end
      if (bus.o_busy === 1'b1) busy_cnt++;
      if (bus.o_clr_done === 1'b1) done_cyc = cyc;
      step();
      idle_inputs();
    end
    n_checks++;
    if (busy_cnt != 32 || done_cyc != 33) begin
      n_fail++;
      $display("FAIL clear_timing: busy_cycles=%0d done_cycle=%0d expected 32/33", busy_cnt, done_cyc);
    end
    for (int a = 0; a < int'(NREG); a++) begin
      set_rd(1, AW'(a));
      #1;
      n_checks++;
      if (bus.o_rd_data[DW +: DW] !== '0 || bus.o_rd_pending[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL cleared_x%0d: got %h/%b expected 0/0", a, bus.o_rd_data[DW +: DW],
                 bus.o_rd_pending[1]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int guard;
    bit saw_done;
    idle_inputs();
    for (int i = 1; i < int'(NREG); i++) begin
      set_wr(1, AW'(i), $urandom | 32'h1);
      step();
      idle_inputs();
    end
    bus.i_clr_req = 1'b1;
    step();
    idle_inputs();
    guard = 0;
    while (mdl_clr != 11 && guard < 100) begin
      step();
      guard++;
    end
    n_checks++;
    if (bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midclear_busy: got %b expected 1", bus.o_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    for (int r = 0; r < int'(NR); r++) set_rd(r, AW'(20 + r));
    #1;
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_clr_done !== 1'b0 || bus.o_rd_data !== '0) begin
      n_fail++;
      $display("FAIL midclear_reset: busy=%b done=%b rd=%h expected 0/0/0", bus.o_busy,
               bus.o_clr_done, bus.o_rd_data);
    end
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.o_clr_done === 1'b1 || bus.o_busy === 1'b1) saw_done = 1'b1;
      step();
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL midclear_no_done: busy/done seen=1 expected 0");
    end
    for (int a = 0; a < int'(NREG); a++) begin
      set_rd(2, AW'(a));
      #1;
      n_checks++;
      if (bus.o_rd_data[2*DW +: DW] !== '0) begin
        n_fail++;
        $display("FAIL midclear_x%0d: got %h expected 0", a, bus.o_rd_data[2*DW +: DW]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_now;
    idle_inputs();
    set_wr(0, 5'd9, 32'h11111111);
    step();
    idle_inputs();
    set_wr(0, 5'd9, 32'hA5A5A5A5);
    set_rd(0, 5'd9);
`ifdef REGFILE_MP_BYPASS_EN
    exp_now = 32'hA5A5A5A5;
`else
    exp_now = 32'h11111111;
`endif
    #1;
    n_checks++;
    if (bus.o_rd_data[0 +: DW] !== exp_now) begin
      n_fail++;
      $display("FAIL same_cycle_x9: got %h expected %h", bus.o_rd_data[0 +: DW], exp_now);
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.o_rd_data[0 +: DW] !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL next_cycle_x9: got %h expected a5a5a5a5", bus.o_rd_data[0 +: DW]);
    end
  endtask

  initial begin
    test_reset();
    test_write_priority();
    test_scoreboard();
    test_random(300);
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    test_random(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port integer register file for the RV32I core, successor to the single-write/dual-read file.
- NUM_RD combinational read ports and two synchronous write ports (EX-late and WB).
- Per-register pending scoreboard for hazard detection.
- Sequential clear engine that zeroes the array without asserting reset.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers
DATA_WIDTH, 32, register data width
NUM_RD, 3, number of read ports (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
i_we  in  2  write enable per write port; bit1 = port 1
i_wr_addr  in  2*ADDR_WIDTH  write addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
i_wr_data  in  2*DATA_WIDTH  write data; port p at [p*DATA_WIDTH +: DATA_WIDTH]
i_rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses, packed per port
o_rd_data  out  NUM_RD*DATA_WIDTH  read data, packed per port
o_rd_pending  out  NUM_RD  pending bit of each addressed register
i_sb_set  in  1  mark i_sb_addr pending (producer issued)
i_sb_addr  in  ADDR_WIDTH  scoreboard set address
i_clr_req  in  1  single-cycle request to zero the whole file
o_busy  out  1  clear engine active
o_clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (rst=1, asynchronous):
  - all registers and pending bits go to 0; FSM goes to IDLE.
  - o_busy=0, o_clr_done=0; o_rd_data=0 and o_rd_pending=0 for every port.
- Reads are combinational, zero latency.
  - Address 0 always returns 0 with pending 0.
  - Otherwise return the array content and the pending bit.
- Writes take effect on the rising edge with i_we[p]=1; data is visible to reads the next cycle.
  - Writes to address 0 are discarded.
  - Both ports writing the same address: port 1 data wins.
- Scoreboard:
  - i_sb_set=1 with i_sb_addr!=0 sets pending[i_sb_addr] at the edge.
  - An accepted write to address a clears pending[a].
  - Set and write to the same address in the same cycle: set wins and pending stays 1.
  - i_sb_addr=0 is ignored.
- Clear FSM states IDLE, CLEAR, DONE:
  - IDLE: i_clr_req=1 -> CLEAR with index counter=0; o_busy=1 from the next cycle.
  - CLEAR: each cycle, register[index] and pending[index] go to 0 and index increments.
  - CLEAR: after index 2**ADDR_WIDTH-1 -> DONE. The counter is ADDR_WIDTH bits; it wraps to 0 on exit and never beyond.
  - DONE: o_clr_done=1 and o_busy=0 for exactly one cycle -> IDLE.
  - While in CLEAR or DONE: i_we, i_sb_set and i_clr_req are ignored. Upstream must stall on o_busy.
  - Reads stay valid throughout; already-cleared entries read 0, the rest read old contents.
- Reset asserted mid-clear: immediate return to IDLE with the full reset state; no o_clr_done pulse.
- Clear latency: request at cycle 0 -> o_busy cycles 1..2**ADDR_WIDTH -> o_clr_done at cycle 2**ADDR_WIDTH+1.

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding. When a read port addresses a register (not address 0) that a write port is writing this cycle, o_rd_data returns the incoming i_wr_data the same cycle. Port 1 has priority when both ports write that address. o_rd_pending for that port reads 0 unless i_sb_set targets the same address this cycle.
- Forwarding is suppressed while o_busy=1 or in DONE.
- Not defined: reads return the pre-edge array contents and pending bits with no forwarding.

Test Plan:
- Reset then read all ports at addresses 0, 5, 31 -> o_rd_data=0, o_rd_pending=0.
- Port 0 writes 0xDEADBEEF to x7 and port 1 writes 0x12345678 to x7 in the same cycle -> next cycle read x7 = 0x12345678; write 0xFFFFFFFF to x0 -> x0 reads 0.
- i_sb_set on x3 -> o_rd_pending=1 on a port reading x3. Write x3 -> pending 0 next cycle. Set plus write x3 in the same cycle -> pending stays 1 and data is updated.
- Fill x1..x31 with their index values, pulse i_clr_req -> o_busy high for 32 cycles, o_clr_done pulse at cycle 33, all reads 0. A write attempted during busy is not applied.
- Pulse rst mid-clear at index 10 -> o_busy=0 immediately, no o_clr_done, all registers 0.
- With REGFILE_MP_BYPASS_EN, write 0xA5A5A5A5 to x9 while reading x9 -> same-cycle o_rd_data=0xA5A5A5A5. Without the macro, the old value is returned that cycle and the new value the next.
